// File: rtl/loader_pkg.sv
// Shared constants for the ioctl download sequencer: state codes, image modes,
// default raw bank bases, BASIC pointer list and the autorun keystroke table.
package loader_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_HDR_LO = 3'd1;
  localparam logic [2:0] ST_HDR_HI = 3'd2;
  localparam logic [2:0] ST_DATA   = 3'd3;
  localparam logic [2:0] ST_FIXUP  = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;

  typedef enum logic [1:0] {
    MODE_PRG  = 2'd0,
    MODE_CART = 2'd1,
    MODE_RAW  = 2'd2
  } mode_t;

  localparam logic [63:0] DEF_RAW_BASES = {16'hB000, 16'hA000, 16'h6000, 16'h4000};
  localparam logic [63:0] DEF_PTR_LIST  = {16'h00AE, 16'h0031, 16'h002F, 16'h002D};

  // "RUN<CR>" stuffed into the keyboard buffer, then the buffer count
  localparam int          AUTORUN_LEN   = 5;
  localparam logic [79:0] AUTORUN_ADDRS = {16'h00C6, 16'h027A, 16'h0279, 16'h0278, 16'h0277};
  localparam logic [39:0] AUTORUN_DATA  = {8'h04, 8'h0D, 8'h4E, 8'h55, 8'h52};

endpackage

// File: rtl/loader_fixup_seq.sv
// Table-driven write emitter: walks N {addr,data,enable} entries, one slot every
// two cycles; disabled entries keep their slot but produce no write.
module loader_fixup_seq #(
  parameter int ADDR_W = 16,
  parameter int N      = 8
) (
  input  logic                clk_sys,
  input  logic                reset,
  input  logic                start,
  input  logic                abort,
  input  logic [N*ADDR_W-1:0] tbl_addr,
  input  logic [N*8-1:0]      tbl_data,
  input  logic [N-1:0]        tbl_en,
  output logic                wr,
  output logic [ADDR_W-1:0]   addr,
  output logic [7:0]          data,
  output logic                finished
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic          running;
  logic          phase;
  logic [IW-1:0] idx;

  assign finished = running & phase & (idx == IW'(N - 1));

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      running <= 1'b0;
      phase   <= 1'b0;
      idx     <= '0;
      wr      <= 1'b0;
      addr    <= '0;
      data    <= '0;
    end else begin
      wr <= 1'b0;
      if (abort) begin
        running <= 1'b0;
        phase   <= 1'b0;
        idx     <= '0;
      end else if (start) begin
        running <= 1'b1;
        phase   <= 1'b0;
        idx     <= '0;
      end else if (running) begin
        phase <= ~phase;
        if (!phase) begin
          wr   <= tbl_en[idx];
          addr <= tbl_addr[idx*ADDR_W +: ADDR_W];
          data <= tbl_data[idx*8 +: 8];
        end else if (finished) begin
          running <= 1'b0;
        end else begin
          idx <= idx + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/prg_cart_loader.sv
// Download sequencer from the hps_io ioctl stream to the core config bus (PRG,
// CART, raw banks). Define LOADER_AUTORUN_EN to append the "RUN" keystrokes after PRG fixups.
module prg_cart_loader
  import loader_pkg::*;
#(
  parameter int                      ADDR_W     = 16,
  parameter int                      NBLK       = 8,
  parameter int                      PRG_INDEX  = 1,
  parameter int                      CART_INDEX = 2,
  parameter int                      RAW_INDEX  = 3,
  parameter logic [4*ADDR_W-1:0]     RAW_BASES  = DEF_RAW_BASES,
  parameter logic [ADDR_W-1:0]       PRG_LIMIT  = 16'hA000,
  parameter logic [ADDR_W-1:0]       CART_LIMIT = 16'hC000,
  parameter int                      NPAIR      = 4,
  parameter logic [NPAIR*ADDR_W-1:0] PTR_LIST   = DEF_PTR_LIST
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ioctl_download,
  input  logic [7:0]        ioctl_index,
  input  logic              ioctl_wr,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
`ifdef LOADER_AUTORUN_EN
  input  logic              autorun,
`endif
  output logic [ADDR_W-1:0] dl_addr,
  output logic [7:0]        dl_data,
  output logic              dl_wr,
  output logic [NBLK-1:0]   cart_blk,
  output logic              cart_hold,
  output logic              busy,
  output logic              done,
  output logic              overflow
);

`ifdef LOADER_AUTORUN_EN
  localparam int NSEQ = 2*NPAIR + AUTORUN_LEN;
`else
  localparam int NSEQ = 2*NPAIR;
`endif

  logic [2:0]          state, state_n;
  mode_t               mode, mode_n;
  logic [ADDR_W:0]     cnt, cnt_n;
  logic [ADDR_W:0]     limit;
  logic                dl_prev, rise;
  logic                data_wr_q, data_wr_n;
  logic [ADDR_W-1:0]   data_addr_q, data_addr_n;
  logic [7:0]          data_byte_q, data_byte_n;
  logic                ovf_n, hold_n;
  logic [NBLK-1:0]     blk_n;
  logic                seq_start, seq_abort, seq_finished;
  logic                seq_wr;
  logic [ADDR_W-1:0]   seq_addr;
  logic [7:0]          seq_data;
  logic [NSEQ*ADDR_W-1:0] seq_tbl_addr;
  logic [NSEQ*8-1:0]   seq_tbl_data;
  logic [NSEQ-1:0]     seq_tbl_en;
  logic                unused_inputs;

  assign unused_inputs = ^{ioctl_addr, ioctl_index[5]};
  assign rise          = ioctl_download & ~dl_prev;
  assign busy          = (state != ST_IDLE);
  assign done          = (state == ST_DONE);
  assign dl_wr         = data_wr_q | seq_wr;
  assign dl_addr       = seq_wr ? seq_addr : data_addr_q;
  assign dl_data       = seq_wr ? seq_data : data_byte_q;

  // Fixup table: pointer pairs get the end address lo/hi; the counter is frozen in FIXUP.
  always_comb begin
    seq_tbl_addr = '0;
    seq_tbl_data = '0;
    seq_tbl_en   = '1;
    for (int k = 0; k < NPAIR; k++) begin
      seq_tbl_addr[(2*k)*ADDR_W +: ADDR_W]   = PTR_LIST[k*ADDR_W +: ADDR_W];
      seq_tbl_addr[(2*k+1)*ADDR_W +: ADDR_W] = PTR_LIST[k*ADDR_W +: ADDR_W] + ADDR_W'(1);
      seq_tbl_data[(2*k)*8 +: 8]             = cnt[7:0];
      seq_tbl_data[(2*k+1)*8 +: 8]           = cnt[15:8];
    end
`ifdef LOADER_AUTORUN_EN
    for (int j = 0; j < AUTORUN_LEN; j++) begin
      seq_tbl_addr[(2*NPAIR+j)*ADDR_W +: ADDR_W] = ADDR_W'(AUTORUN_ADDRS[j*16 +: 16]);
      seq_tbl_data[(2*NPAIR+j)*8 +: 8]           = AUTORUN_DATA[j*8 +: 8];
      seq_tbl_en[2*NPAIR+j]                      = autorun;
    end
`endif
  end

  always_comb begin
    state_n     = state;
    mode_n      = mode;
    cnt_n       = cnt;
    data_wr_n   = 1'b0;
    data_addr_n = data_addr_q;
    data_byte_n = data_byte_q;
    ovf_n       = overflow;
    hold_n      = cart_hold;
    blk_n       = cart_blk;
    seq_start   = 1'b0;
    seq_abort   = 1'b0;
    limit       = (mode == MODE_PRG) ? {1'b0, PRG_LIMIT} : {1'b0, CART_LIMIT};

    if (ioctl_wr) begin
      case (state)
        ST_HDR_LO: begin
          cnt_n[7:0] = ioctl_dout;
          state_n    = ST_HDR_HI;
        end
        ST_HDR_HI: begin
          cnt_n[15:8] = ioctl_dout;
          state_n     = ST_DATA;
        end
        ST_DATA: begin
          if (cnt < limit) begin
            data_wr_n   = 1'b1;
            data_addr_n = cnt[ADDR_W-1:0];
            data_byte_n = ioctl_dout;
            cnt_n       = cnt + 1'b1;
            if (mode != MODE_PRG) blk_n[cnt[ADDR_W-1 -: 3]] = 1'b1;
          end else begin
            ovf_n = 1'b1;
          end
        end
        default: ;
      endcase
    end

    // End of stream is evaluated after any byte arriving in the same cycle.
    if (!ioctl_download && (state == ST_HDR_LO || state == ST_HDR_HI || state == ST_DATA)) begin
      if (mode == MODE_PRG) begin
        if (state_n == ST_DATA) begin
          state_n   = ST_FIXUP;
          seq_start = 1'b1;
        end else begin
          state_n = ST_DONE;
          ovf_n   = 1'b1;
        end
      end else begin
        state_n = ST_DONE;
        hold_n  = 1'b0;
      end
    end

    if (state == ST_FIXUP && seq_finished) state_n = ST_DONE;
    if (state == ST_DONE) state_n = ST_IDLE;

    if (rise && (state == ST_IDLE || state == ST_FIXUP)) begin
      if (ioctl_index[4:0] == 5'(PRG_INDEX) || ioctl_index[4:0] == 5'(CART_INDEX)) begin
        seq_abort = (state == ST_FIXUP);
        mode_n    = (ioctl_index[4:0] == 5'(PRG_INDEX)) ? MODE_PRG : MODE_CART;
        hold_n    = (ioctl_index[4:0] != 5'(PRG_INDEX));
        state_n   = ST_HDR_LO;
        cnt_n     = '0;
        ovf_n     = 1'b0;
      end else if (ioctl_index[4:0] == 5'(RAW_INDEX)) begin
        seq_abort = (state == ST_FIXUP);
        mode_n    = MODE_RAW;
        hold_n    = 1'b1;
        state_n   = ST_DATA;
        cnt_n     = {1'b0, RAW_BASES[ioctl_index[7:6]*ADDR_W +: ADDR_W]};
        ovf_n     = 1'b0;
      end
    end
  end

  // dl_prev resets high so a download already running at reset release is ignored.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      mode        <= MODE_PRG;
      cnt         <= '0;
      dl_prev     <= 1'b1;
      data_wr_q   <= 1'b0;
      data_addr_q <= '0;
      data_byte_q <= '0;
      overflow    <= 1'b0;
      cart_hold   <= 1'b0;
      cart_blk    <= '0;
    end else begin
      state       <= state_n;
      mode        <= mode_n;
      cnt         <= cnt_n;
      dl_prev     <= ioctl_download;
      data_wr_q   <= data_wr_n;
      data_addr_q <= data_addr_n;
      data_byte_q <= data_byte_n;
      overflow    <= ovf_n;
      cart_hold   <= hold_n;
      cart_blk    <= blk_n;
    end
  end

  loader_fixup_seq #(
    .ADDR_W (ADDR_W),
    .N      (NSEQ)
  ) u_fixup (
    .clk_sys  (clk_sys),
    .reset    (reset),
    .start    (seq_start),
    .abort    (seq_abort),
    .tbl_addr (seq_tbl_addr),
    .tbl_data (seq_tbl_data),
    .tbl_en   (seq_tbl_en),
    .wr       (seq_wr),
    .addr     (seq_addr),
    .data     (seq_data),
    .finished (seq_finished)
  );

endmodule
